// File: rtl/score_pkg.sv
// score_pkg: shared FSM encoding, BCD limits and award clamping for the score controller.
package score_pkg;
   typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [15:0] SCORE_MAX = 16'h9999;
   function automatic logic [7:0] clamp_award(input logic [7:0] p);
      return {(p[7:4] > BCD_MAX) ? BCD_MAX : p[7:4], (p[3:0] > BCD_MAX) ? BCD_MAX : p[3:0]};
   endfunction
endpackage

// File: rtl/score_if.sv
// score_if: award request bus between requesters and the score controller.
interface score_if #(parameter int NREQ = 3);
   logic [NREQ-1:0] req;
   logic [8*NREQ-1:0] pts;
   logic [NREQ-1:0] ack;
   modport master(output req, pts, input ack);
   modport slave(input req, pts, output ack);
endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single-digit decimal adder with carry in/out.
module bcd_digit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] t;
   assign t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
   assign cout = t > 5'd9;
   assign sum = cout ? 4'(t - 5'd10) : t[3:0];
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: round-robin award arbiter with a digit-serial BCD score adder,
// saturating score, high-score tracking and a free-running display scan strobe.
module score_ctrl import score_pkg::*; #(
   parameter int NREQ = 3,
   parameter int SCAN_DIV = 16
) (
   input  logic        cclk,
   input  logic        clr,
   input  logic        game_rst,
   score_if.slave      bus,
   output logic [15:0] score,
   output logic [15:0] hiscore,
   output logic        busy,
   output logic        sat,
   output logic        scan_tick
);
   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   state_t state, nxt;
   logic [1:0] ptr, gidx, dcnt;
   logic found, grant, carry, dcout;
   logic [7:0] award;
   logic [15:0] acc, commit_val;
   logic [3:0] bdig, dsum;
   logic [SW-1:0] scnt;
   always_comb begin
      found = 1'b0;
      gidx = ptr;
      for (int k = 0; k < NREQ; k++)
         if (!found && bus.req[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            gidx = 2'((int'(ptr) + k) % NREQ);
         end
   end
   // clr gates the combinational grant so no ack escapes while reset is held
   assign grant = !clr && state == IDLE && !game_rst && found;
   assign bus.ack = grant ? NREQ'(1) << gidx : '0;
   assign busy = state != IDLE;
   always_comb begin
      nxt = game_rst ? IDLE :
            state == IDLE ? (found ? ADD : IDLE) :
            state == ADD ? (dcnt == 2'd3 ? COMMIT : ADD) : IDLE;
   end
   always_ff @(posedge cclk or posedge clr)
      if (clr) state <= IDLE;
      else state <= nxt;
   assign bdig = dcnt[1] ? 4'd0 : award[{dcnt[0], 2'b00} +: 4];
   bcd_digit_add u_add (.a(acc[{dcnt, 2'b00} +: 4]), .b(bdig), .cin(carry), .sum(dsum), .cout(dcout));
   assign commit_val = carry ? SCORE_MAX : acc;
   always_ff @(posedge cclk or posedge clr)
      if (clr) begin
         ptr <= 2'd0;
         dcnt <= 2'd0;
         carry <= 1'b0;
         award <= 8'd0;
         acc <= 16'd0;
         score <= 16'd0;
         hiscore <= 16'd0;
         sat <= 1'b0;
      end else begin
         if (grant) begin
            ptr <= (gidx == 2'(NREQ - 1)) ? 2'd0 : gidx + 2'd1;
            award <= clamp_award(bus.pts[{gidx, 3'b000} +: 8]);
            acc <= score;
            dcnt <= 2'd0;
            carry <= 1'b0;
         end
         if (state == ADD) begin
            acc[{dcnt, 2'b00} +: 4] <= dsum;
            carry <= dcout;
            dcnt <= dcnt + 2'd1;
         end
         if (game_rst) begin
            score <= 16'd0;
            sat <= 1'b0;
         end else if (state == COMMIT) begin
            score <= commit_val;
            sat <= sat | carry;
            if (commit_val > hiscore) hiscore <= commit_val;
         end
      end
   always_ff @(posedge cclk or posedge clr)
      if (clr) scnt <= '0;
      else scnt <= (scnt == SW'(SCAN_DIV - 1)) ? '0 : scnt + 1'b1;
   assign scan_tick = scnt == SW'(SCAN_DIV - 1);
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed and random award sequences checked against a decimal score model.
module tb_score_ctrl;
   logic cclk = 1'b0, clr = 1'b1, game_rst = 1'b0;
   logic [15:0] score, hiscore;
   logic busy, sat, scan_tick;
   int n_chk = 0, n_fail = 0;
   int m_score = 0, m_hi = 0, m_sat = 0, rr = 0;
   score_if #(.NREQ(3)) bus();
   score_ctrl #(.NREQ(3), .SCAN_DIV(16)) dut (
      .cclk(cclk), .clr(clr), .game_rst(game_rst), .bus(bus),
      .score(score), .hiscore(hiscore), .busy(busy), .sat(sat), .scan_tick(scan_tick)
   );
   always #5 cclk = ~cclk;
   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   function automatic int award_val(input logic [7:0] p);
      int hi, lo;
      hi = (p[7:4] > 9) ? 9 : int'(p[7:4]);
      lo = (p[3:0] > 9) ? 9 : int'(p[3:0]);
      return hi * 10 + lo;
   endfunction
   function automatic int pick(input logic [2:0] r, input int start);
      for (int k = 0; k < 3; k++)
         if (r[(start + k) % 3]) return (start + k) % 3;
      return -1;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask
   task automatic chk_state(input string tag);
      chk({tag, "_score"}, 32'(score), 32'(to_bcd(m_score)));
      chk({tag, "_hiscore"}, 32'(hiscore), 32'(to_bcd(m_hi)));
      chk({tag, "_sat"}, 32'(sat), 32'(m_sat));
   endtask
   // Starts at an idle negedge (cycle T); returns at the negedge of T+6.
   task automatic award(input logic [2:0] r, input logic [23:0] p, input bit hold);
      int g, nv;
      g = pick(r, rr);
      bus.req = r;
      bus.pts = p;
      #1;
      chk("grant_ack", 32'(bus.ack), 32'(1 << g));
      rr = (g + 1) % 3;
      nv = m_score + award_val(p[8*g +: 8]);
      @(negedge cclk);
      if (!hold) bus.req = r & ~3'(1 << g);
      for (int c = 1; c <= 5; c++) begin
         chk("busy_during", 32'(busy), 32'd1);
         chk("no_ack_busy", 32'(bus.ack), 32'd0);
         chk("score_hold", 32'(score), 32'(to_bcd(m_score)));
         @(negedge cclk);
      end
      if (nv > 9999) begin
         nv = 9999;
         m_sat = 1;
      end
      m_score = nv;
      if (nv > m_hi) m_hi = nv;
      chk("busy_done", 32'(busy), 32'd0);
      chk_state("commit");
      if (!hold) bus.req = 3'b000;
   endtask
   task automatic do_game_rst();
      bus.req = 3'b111;
      game_rst = 1'b1;
      #1;
      chk("gr_no_ack", 32'(bus.ack), 32'd0);
      @(negedge cclk);
      game_rst = 1'b0;
      bus.req = 3'b000;
      m_score = 0;
      m_sat = 0;
      chk("gr_busy", 32'(busy), 32'd0);
      chk_state("game_rst");
   endtask
   task automatic reach(input int target);
      int rem, v;
      logic [15:0] b;
      do_game_rst();
      rem = target;
      while (rem > 0) begin
         v = (rem > 99) ? 99 : rem;
         b = to_bcd(v);
         award(3'b001, {16'h0, b[7:0]}, 1'b0);
         rem -= v;
      end
   endtask
   task automatic scan_check();
      for (int k = 0; k < 34; k++) begin
         chk("scan_tick", 32'(scan_tick), 32'((k % 16) == 15));
         @(negedge cclk);
      end
   endtask
   initial begin
      logic [2:0] r;
      logic [23:0] p;
      int g;
      bus.req = 3'b111;
      bus.pts = '0;
      repeat (2) @(negedge cclk);
      #1;
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tick", 32'(scan_tick), 32'd0);
      chk_state("rst");
      @(negedge cclk);
      bus.req = 3'b000;
      clr = 1'b0;
      scan_check();
      award(3'b001, 24'h000025, 1'b0);
      reach(200);
      g = pick(3'b001, rr);
      bus.req = 3'b001;
      bus.pts = 24'h000050;
      #1;
      chk("abort_ack", 32'(bus.ack), 32'(1 << g));
      rr = (g + 1) % 3;
      @(negedge cclk);
      bus.req = 3'b000;
      @(negedge cclk);
      @(negedge cclk);
      game_rst = 1'b1;
      chk("abort_busy", 32'(busy), 32'd1);
      @(negedge cclk);
      game_rst = 1'b0;
      m_score = 0;
      m_sat = 0;
      chk("abort_idle", 32'(busy), 32'd0);
      chk_state("abort");
      reach(999);
      award(3'b001, 24'h000001, 1'b0);
      award(3'b010, 24'h00AF00, 1'b0);
      award(3'b100, 24'h000000, 1'b0);
      reach(9990);
      award(3'b001, 24'h000015, 1'b0);
      award(3'b001, 24'h000001, 1'b0);
      do_game_rst();
      g = pick(3'b001, rr);
      bus.req = 3'b001;
      bus.pts = 24'h000033;
      #1;
      chk("clr_ack", 32'(bus.ack), 32'(1 << g));
      @(negedge cclk);
      bus.req = 3'b000;
      @(negedge cclk);
      clr = 1'b1;
      #1;
      m_score = 0;
      m_hi = 0;
      m_sat = 0;
      rr = 0;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_ack0", 32'(bus.ack), 32'd0);
      chk("clr_tick", 32'(scan_tick), 32'd0);
      chk_state("clr");
      @(negedge cclk);
      clr = 1'b0;
      scan_check();
      for (int i = 0; i < 3; i++) award(3'b111, 24'h010101, 1'b1);
      award(3'b111, 24'h010101, 1'b0);
      for (int i = 0; i < 40; i++) begin
         r = 3'($urandom_range(1, 7));
         p = 24'($urandom);
         if ($urandom_range(0, 9) == 0) do_game_rst();
         repeat ($urandom_range(0, 2)) @(negedge cclk);
         award(r, p, 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of point-award requesters (2..4).
REQ-002 SHALL have parameter SCAN_DIV, default 16, scan_tick period in cclk cycles (>=2).
REQ-003 SHALL have port cclk  input  1  rising-edge clock.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester award request; held until acked.
REQ-006 SHALL have port pts  input  8*NREQ  per-requester award, 2 BCD digits; requester i owns bits [8i+7:8i].
REQ-007 SHALL have port game_rst  input  1  synchronous clear of current score.
REQ-008 SHALL have port ack  output  NREQ  one-hot, one-cycle grant/accept pulse.
REQ-009 SHALL have port score  output  16  current score, 4 packed BCD digits, digit 0 in [3:0].
REQ-010 SHALL have port hiscore  output  16  best score since clr, packed BCD.
REQ-011 SHALL have port busy  output  1  high while an award is being applied.
REQ-012 SHALL have port sat  output  1  sticky flag: score saturated at 9999.
REQ-013 SHALL have port scan_tick  output  1  one-cycle pulse, display digit-advance strobe.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, COMMIT; busy = (state != IDLE).
REQ-015 In IDLE with any req high and game_rst low, SHALL grant exactly one requester round-robin, starting search at (last_grant+1) mod NREQ; pointer resets to 0.
REQ-016 Grant cycle T: ack[i]=1 for that cycle only, pts[i] latched at edge ending T, FSM -> ADD.
REQ-017 ADD SHALL last exactly 4 cycles (T+1..T+4), adding one BCD digit per cycle, digit 0 first, with decimal carry; award digits 2,3 are zero.
REQ-018 Award digits >9 SHALL be clamped to 9 before addition.
REQ-019 COMMIT (T+5) SHALL write the sum to score; new score visible from T+6; FSM -> IDLE at T+6.
REQ-020 Carry out of digit 3 SHALL force score = 16'h9999 and set sat; sat stays 1 until game_rst or clr.
REQ-021 At COMMIT, if new score > hiscore (packed-BCD compare as unsigned), hiscore SHALL load new score in same edge.
REQ-022 req SHALL be ignored while busy; no ack issued outside IDLE; earliest next ack is T+6.
REQ-023 Award pts = 8'h00 SHALL complete full handshake and timing with score unchanged.
REQ-024 game_rst in IDLE SHALL clear score and sat next edge; no ack that cycle even if req high.
REQ-025 game_rst in ADD or COMMIT SHALL abort: no commit, score and sat cleared, FSM -> IDLE next edge; hiscore unaffected.
REQ-026 scan_tick SHALL come from a free-running counter 0..SCAN_DIV-1, pulsing when counter = SCAN_DIV-1, independent of FSM and game_rst.

Reset
REQ-027 clr SHALL asynchronously force: state IDLE, ack 0, score 0, hiscore 0, sat 0, busy 0, scan counter 0, scan_tick 0, RR pointer 0.
REQ-028 Deassertion of clr SHALL not by itself produce an ack; first grant possible on the first edge after clr low.

Structure
REQ-029 Shared package score_pkg SHALL hold state encoding, BCD_MAX (4'd9), SCORE_MAX (16'h9999).
REQ-030 Single-digit BCD adder (a, b, cin -> sum, cout) SHALL be a combinational sub-module bcd_digit_add, instantiated once, reused per ADD cycle.

Verification
REQ-031 Single award: score 0, req[0]=1, pts0=8'h25 -> ack[0] at T, busy T+1..T+5, score 16'h0025 at T+6, hiscore 16'h0025.
REQ-032 Carry chain: score 16'h0999, award 8'h01 -> score 16'h1000, sat 0.
REQ-033 Saturation: score 16'h9990, award 8'h15 -> score 16'h9999, sat 1; further award 8'h01 -> stays 9999, sat 1.
REQ-034 Arbitration: req=3'b111 held continuously -> acks in order 0,1,2,0 spaced 6 cycles; each ack exactly one cycle.
REQ-035 Abort: game_rst at T+3 of award 8'h50 on score 16'h0200 -> score 0 at T+4, FSM IDLE, hiscore 16'h0200 unchanged.
REQ-036 clr mid-ADD and scan_tick: clr asserted mid-ADD -> all outputs reset immediately; with SCAN_DIV=16, scan_tick pulses every 16 cycles, first 16 cycles after clr release.
